sd_cmd_seq: RTL

SD_CMD_SEQ -- requirements
Module: sd_cmd_seq

---
 rtl/sd_types.sv | 4 +
 rtl/sdspi_types.sv | 16 +
 rtl/sd_crc7.sv | 22 ++
 rtl/sd_cmd_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sd_types.sv
// Shared SD card data types.
package sd_types;
  typedef logic [7:0] sdBYTE_t;
endpackage

// File: rtl/sdspi_types.sv
// sdspi byte-engine operations and command-sequencer state encoding.
package sdspi_types;
  typedef enum logic [1:0] {
    spiNOP,
    spiCSL,
    spiCSH,
    spiTR
  } spiOP_t;

  typedef enum logic [3:0] {
    IDLE, CSL, TXB, TXW, POLL,
    POLLW, CSH, TAIL, TAILW, FIN
  } cmd_state_t;

  localparam logic [1:0] SD_CMD_START = 2'b01;
endpackage

// File: rtl/sd_crc7.sv
// Combinational CRC7 (x^7+x^3+1, init 0), MSB-first over 40 bits.
// Only built when SD_CMD_CRC_EN is defined.
`ifdef SD_CMD_CRC_EN
module sd_crc7 (
  input  logic [39:0] data_i,
  output logic [6:0]  crc_o
);
  logic [6:0] c;
  logic       fb;

  always_comb begin
    c  = 7'd0;
    fb = 1'b0;
    for (int i = 39; i >= 0; i--) begin
      fb = data_i[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    crc_o = c;
  end
endmodule
`endif

// File: rtl/sd_cmd_seq.sv
// SD SPI-mode command sequencer: CS, 6 command bytes, R1 poll, tail.
// SD_CMD_CRC_EN selects a computed CRC7 instead of fixed CRC bytes.
module sd_cmd_seq
  import sdspi_types::*;
  import sd_types::*;
#(
  parameter int NCR_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmdSTART,
  input  logic [5:0]  cmdIDX,
  input  logic [31:0] cmdARG,
  input  logic        cmdKEEPCS,
  output logic        cmdBUSY,
  output logic        cmdDONE,
  output logic [7:0]  cmdR1,
  output logic        cmdTIMEOUT,
  output spiOP_t      spiOP,
  output sdBYTE_t     spiTXD,
  input  sdBYTE_t     spiRXD,
  input  logic        spiDONE
);
  cmd_state_t state_q, state_d;
  spiOP_t     op_q, op_d;
  sdBYTE_t    txd_q, txd_d;
  sdBYTE_t    r1_q, r1_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       to_q, to_d;
  logic       keep_q, keep_d;
  logic [5:0] idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic [2:0] n_q, n_d;
  logic [3:0] poll_q, poll_d;
  logic [3:0] poll_nx;
  sdBYTE_t    crc_byte;
  sdBYTE_t    cmd_byte;

`ifdef SD_CMD_CRC_EN
  logic [6:0] crc7;
  sd_crc7 u_crc7 (
    .data_i({SD_CMD_START, idx_q, arg_q}),
    .crc_o (crc7)
  );
  assign crc_byte = {crc7, 1'b1};
`else
  // Only CMD0 and CMD8 need a valid CRC before CRC checking is off.
  assign crc_byte = (idx_q == 6'd0) ? 8'h95 :
                    (idx_q == 6'd8) ? 8'h87 : 8'h01;
`endif

  always_comb begin
    case (n_q)
      3'd0:    cmd_byte = {SD_CMD_START, idx_q};
      3'd1:    cmd_byte = arg_q[31:24];
      3'd2:    cmd_byte = arg_q[23:16];
      3'd3:    cmd_byte = arg_q[15:8];
      3'd4:    cmd_byte = arg_q[7:0];
      3'd5:    cmd_byte = crc_byte;
      default: cmd_byte = 8'hFF;
    endcase
  end

  assign poll_nx = poll_q + 4'd1;

  always_comb begin
    state_d = state_q;
    op_d    = spiNOP;
    txd_d   = txd_q;
    r1_d    = r1_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    to_d    = to_q;
    keep_d  = keep_q;
    idx_d   = idx_q;
    arg_d   = arg_q;
    n_d     = n_q;
    poll_d  = poll_q;
    case (state_q)
      IDLE: if (cmdSTART) begin
        idx_d   = cmdIDX;
        arg_d   = cmdARG;
        keep_d  = cmdKEEPCS;
        busy_d  = 1'b1;
        to_d    = 1'b0;
        state_d = CSL;
      end
      CSL: begin
        op_d    = spiCSL;
        n_d     = 3'd0;
        state_d = TXB;
      end
      TXB: begin
        op_d    = spiTR;
        txd_d   = cmd_byte;
        state_d = TXW;
      end
      TXW: if (spiDONE) begin
        if (n_q < 3'd5) begin
          n_d     = n_q + 3'd1;
          state_d = TXB;
        end else begin
          poll_d  = 4'd0;
          state_d = POLL;
        end
      end
      POLL: begin
        op_d    = spiTR;
        txd_d   = 8'hFF;
        state_d = POLLW;
      end
      POLLW: if (spiDONE) begin
        if (!spiRXD[7]) begin
          r1_d    = spiRXD;
          state_d = keep_q ? FIN : CSH;
        end else begin
          poll_d = poll_nx;
          if (poll_nx == 4'(NCR_MAX)) begin
            r1_d    = 8'hFF;
            to_d    = 1'b1;
            state_d = keep_q ? FIN : CSH;
          end else begin
            state_d = POLL;
          end
        end
      end
      CSH: begin
        op_d    = spiCSH;
        state_d = TAIL;
      end
      TAIL: begin
        op_d    = spiTR;
        txd_d   = 8'hFF;
        state_d = TAILW;
      end
      TAILW: if (spiDONE) state_d = FIN;
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= spiNOP;
      txd_q   <= 8'hFF;
      r1_q    <= 8'hFF;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      keep_q  <= 1'b0;
      idx_q   <= 6'd0;
      arg_q   <= 32'd0;
      n_q     <= 3'd0;
      poll_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      txd_q   <= txd_d;
      r1_q    <= r1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      to_q    <= to_d;
      keep_q  <= keep_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
      n_q     <= n_d;
      poll_q  <= poll_d;
    end
  end

  assign spiOP      = op_q;
  assign spiTXD     = txd_q;
  assign cmdR1      = r1_q;
  assign cmdBUSY    = busy_q;
  assign cmdDONE    = done_q;
  assign cmdTIMEOUT = to_q;
endmodule
